// File: rtl/sd_cmd_arbiter.sv
// sd_cmd_arbiter: two-requester SD command/response sequencer with a response timeout.
// Optional SD_ARB_ROUND_ROBIN_EN: round-robin arbitration instead of fixed priority (requester 0 first).
`timescale 1ns/1ps

module sd_cmd_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic         ex_clk,
    input  logic         ex_resetn,

    input  logic [1:0]   req_valid,
    input  logic [37:0]  req_cmd0,
    input  logic [37:0]  req_cmd1,
    input  logic [1:0]   req_rtype0,
    input  logic [1:0]   req_rtype1,
    output logic [1:0]   req_grant,
    output logic [1:0]   req_done,
    output logic [1:0]   resp_status,
    output logic [126:0] resp_data,
    output logic         busy,

    output logic         send_en,
    output logic [37:0]  send_cmd_content,
    input  logic         sd_sending,
    input  logic         sd_finished,

    output logic         receive_en,
    output logic         R2_response,
    output logic         R3_response,
    input  logic         sd_receive_started,
    input  logic         sd_receive_finished,
    input  logic         crc_response_err,
    input  logic [126:0] response
);

    localparam logic [1:0]      LP_ST_OK      = 2'd0;
    localparam logic [1:0]      LP_ST_CRC     = 2'd1;
    localparam logic [1:0]      LP_ST_TIMEOUT = 2'd2;
    localparam logic [TO_W-1:0] LP_TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

    // IDLE arbitrate | SEND send_en | WAIT_SEND sender busy | RECV receive_en | WAIT_RESP timeout | DONE req_done
    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_SEND,
        S_RECV,
        S_WAIT_RESP,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_owner;
    logic [1:0]      r_rtype;
    logic [37:0]     r_cmd;
    logic [1:0]      r_req_grant;
    logic [1:0]      r_req_done;
    logic [1:0]      r_status;
    logic [126:0]    r_resp_data;
    logic            r_busy;
    logic            r_send_en;
    logic            r_receive_en;
    logic            r_r2;
    logic            r_r3;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_started;

    logic            w_pick_id;
    logic [1:0]      w_pick_rtype;
    logic [37:0]     w_pick_cmd;
    logic [1:0]      w_owner_oh;
    logic            w_unused;

    assign w_unused = sd_sending;

`ifdef SD_ARB_ROUND_ROBIN_EN
    // r_last_id is the last requester granted; it starts at 1 so requester 0 wins first.
    logic r_last_id;

    always_comb begin
        w_pick_id = 1'b0;
        if (req_valid == 2'b11) begin
            w_pick_id = ~r_last_id;
        end else if (req_valid[1]) begin
            w_pick_id = 1'b1;
        end
    end

    always_ff @(posedge ex_clk or negedge ex_resetn) begin
        if (!ex_resetn) begin
            r_last_id <= 1'b1;
        end else if (r_state == S_IDLE && |req_valid) begin
            r_last_id <= w_pick_id;
        end
    end
`else
    always_comb begin
        w_pick_id = 1'b0;
        if (!req_valid[0] && req_valid[1]) begin
            w_pick_id = 1'b1;
        end
    end
`endif

    assign w_pick_rtype = w_pick_id ? req_rtype1 : req_rtype0;
    assign w_pick_cmd   = w_pick_id ? req_cmd1   : req_cmd0;
    assign w_owner_oh   = r_owner   ? 2'b10      : 2'b01;

    always_ff @(posedge ex_clk or negedge ex_resetn) begin
        if (!ex_resetn) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_rtype      <= 2'd0;
            r_cmd        <= '0;
            r_req_grant  <= 2'b00;
            r_req_done   <= 2'b00;
            r_status     <= LP_ST_OK;
            r_resp_data  <= '0;
            r_busy       <= 1'b0;
            r_send_en    <= 1'b0;
            r_receive_en <= 1'b0;
            r_r2         <= 1'b0;
            r_r3         <= 1'b0;
            r_to_cnt     <= '0;
            r_started    <= 1'b0;
        end else begin
            r_req_grant  <= 2'b00;
            r_req_done   <= 2'b00;
            r_send_en    <= 1'b0;
            r_receive_en <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (|req_valid) begin
                        r_owner     <= w_pick_id;
                        r_req_grant <= w_pick_id ? 2'b10 : 2'b01;
                        r_cmd       <= w_pick_cmd;
                        r_rtype     <= w_pick_rtype;
                        r_r2        <= (w_pick_rtype == 2'd2);
                        r_r3        <= (w_pick_rtype == 2'd3);
                        r_send_en   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_SEND;
                    end
                end

                S_SEND: begin
                    r_state <= S_WAIT_SEND;
                end

                S_WAIT_SEND: begin
                    if (sd_finished) begin
                        if (r_rtype == 2'd0) begin
                            r_status   <= LP_ST_OK;
                            r_req_done <= w_owner_oh;
                            r_state    <= S_DONE;
                        end else begin
                            r_receive_en <= 1'b1;
                            r_to_cnt     <= '0;
                            r_started    <= 1'b0;
                            r_state      <= S_RECV;
                        end
                    end
                end

                S_RECV: begin
                    r_to_cnt  <= '0;
                    r_started <= sd_receive_started;
                    r_state   <= S_WAIT_RESP;
                end

                S_WAIT_RESP: begin
                    // A finishing response beats a timeout landing on the same edge.
                    if (sd_receive_finished) begin
                        r_resp_data <= response;
                        r_status    <= crc_response_err ? LP_ST_CRC : LP_ST_OK;
                        r_req_done  <= w_owner_oh;
                        r_state     <= S_DONE;
                    end else if (!r_started) begin
                        if (sd_receive_started) begin
                            r_started <= 1'b1;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                            if (r_to_cnt == LP_TO_LAST) begin
                                r_status   <= LP_ST_TIMEOUT;
                                r_req_done <= w_owner_oh;
                                r_state    <= S_DONE;
                            end
                        end
                    end
                end

                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_grant        = r_req_grant;
    assign req_done         = r_req_done;
    assign resp_status      = r_status;
    assign resp_data        = r_resp_data;
    assign busy             = r_busy;
    assign send_en          = r_send_en;
    assign send_cmd_content = r_cmd;
    assign receive_en       = r_receive_en;
    assign R2_response      = r_r2;
    assign R3_response      = r_r3;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Directed bench for sd_cmd_arbiter with TIMEOUT_CYCLES=16; sender/receiver behaviour is driven by hand.
`timescale 1ns/1ps

module tb_sd_cmd_arbiter;

    localparam int TO = 16;

    localparam logic [37:0]  C0 = 38'h01_0000_0001;
    localparam logic [37:0]  C1 = 38'h02_0000_0002;
    localparam logic [37:0]  C2 = 38'h2A_1234_5678;
    localparam logic [37:0]  C3 = 38'h15_DEAD_BEEF;
    localparam logic [126:0] RV_R2  = 127'h1234_5678_9ABC_DEF0_0F0F_F0F0;
    localparam logic [126:0] RV_TIE = 127'h7E5;

    logic         ex_clk = 1'b0;
    logic         ex_resetn;
    logic [1:0]   req_valid;
    logic [37:0]  req_cmd0, req_cmd1;
    logic [1:0]   req_rtype0, req_rtype1;
    logic [1:0]   req_grant, req_done, resp_status;
    logic [126:0] resp_data;
    logic         busy, send_en, receive_en, R2_response, R3_response;
    logic [37:0]  send_cmd_content;
    logic         sd_sending, sd_finished;
    logic         sd_receive_started, sd_receive_finished, crc_response_err;
    logic [126:0] response;

    int n_vec = 0;
    int n_miscmp = 0;
    int n_send = 0;
    int n_recv = 0;
    int n_done = 0;

    sd_cmd_arbiter #(.TIMEOUT_CYCLES(TO), .TO_W(5)) u_dut (
        .ex_clk              (ex_clk),
        .ex_resetn           (ex_resetn),
        .req_valid           (req_valid),
        .req_cmd0            (req_cmd0),
        .req_cmd1            (req_cmd1),
        .req_rtype0          (req_rtype0),
        .req_rtype1          (req_rtype1),
        .req_grant           (req_grant),
        .req_done            (req_done),
        .resp_status         (resp_status),
        .resp_data           (resp_data),
        .busy                (busy),
        .send_en             (send_en),
        .send_cmd_content    (send_cmd_content),
        .sd_sending          (sd_sending),
        .sd_finished         (sd_finished),
        .receive_en          (receive_en),
        .R2_response         (R2_response),
        .R3_response         (R3_response),
        .sd_receive_started  (sd_receive_started),
        .sd_receive_finished (sd_receive_finished),
        .crc_response_err    (crc_response_err),
        .response            (response)
    );

    always #5 ex_clk = ~ex_clk;

    always @(negedge ex_clk) begin
        if (send_en)     n_send++;
        if (receive_en)  n_recv++;
        if (|req_done)   n_done++;
    end

    task automatic tick();
        @(posedge ex_clk);
        #1;
    endtask

    task automatic chk_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk_val({pfx, "_busy"},  {127'd0, busy},        128'd0);
        chk_val({pfx, "_grant"}, {126'd0, req_grant},   128'd0);
        chk_val({pfx, "_done"},  {126'd0, req_done},    128'd0);
        chk_val({pfx, "_stat"},  {126'd0, resp_status}, 128'd0);
        chk_val({pfx, "_sen"},   {127'd0, send_en},     128'd0);
        chk_val({pfx, "_ren"},   {127'd0, receive_en},  128'd0);
        chk_val({pfx, "_r2r3"},  {126'd0, R2_response, R3_response}, 128'd0);
        chk_val({pfx, "_data"},  {1'b0, resp_data},     128'd0);
        chk_val({pfx, "_cmd"},   {90'd0, send_cmd_content}, 128'd0);
    endtask

    task automatic to_wait_resp();
        tick();
        sd_finished = 1'b1;
        tick();
        sd_finished = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 ns");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_arb2;
        int s0, r0, d0;

`ifdef SD_ARB_ROUND_ROBIN_EN
        exp_arb2 = 2'b10;
`else
        exp_arb2 = 2'b01;
`endif
        ex_resetn = 1'b0;
        req_valid = 2'b00;
        req_cmd0 = '0; req_cmd1 = '0;
        req_rtype0 = 2'd0; req_rtype1 = 2'd0;
        sd_sending = 1'b0; sd_finished = 1'b0;
        sd_receive_started = 1'b0; sd_receive_finished = 1'b0;
        crc_response_err = 1'b0; response = '0;

        tick();
        tick();
        chk_all_zero("rst");
        ex_resetn = 1'b1;
        tick();

        // simultaneous requests held through DONE
        req_cmd0 = C0; req_cmd1 = C1; req_valid = 2'b11;
        tick();
        chk_val("arb1_grant", {126'd0, req_grant}, 128'(2'b01));
        chk_val("arb1_cmd",   {90'd0, send_cmd_content}, 128'(C0));
        tick();
        sd_finished = 1'b1;
        tick();
        sd_finished = 1'b0;
        chk_val("arb1_done",  {126'd0, req_done}, 128'(2'b01));
        tick();
        chk_val("arb_idle_busy", {127'd0, busy}, 128'd0);
        tick();
        chk_val("arb2_grant", {126'd0, req_grant}, 128'(exp_arb2));
        chk_val("arb2_cmd",   {90'd0, send_cmd_content}, (exp_arb2 == 2'b01) ? 128'(C0) : 128'(C1));
        req_valid = 2'b00;
        tick();
        sd_finished = 1'b1;
        tick();
        sd_finished = 1'b0;
        chk_val("arb2_done",  {126'd0, req_done}, 128'(exp_arb2));
        tick();

        // CMD0, no response
        s0 = n_send; r0 = n_recv;
        req_cmd0 = '0; req_rtype0 = 2'd0; req_valid = 2'b01;
        tick();
        chk_val("c0_grant", {126'd0, req_grant}, 128'(2'b01));
        chk_val("c0_sen",   {127'd0, send_en}, 128'd1);
        chk_val("c0_busy",  {127'd0, busy}, 128'd1);
        req_valid = 2'b00;
        tick();
        chk_val("c0_sen_off",   {127'd0, send_en}, 128'd0);
        chk_val("c0_grant_off", {126'd0, req_grant}, 128'd0);
        tick();
        tick();
        chk_val("c0_no_early_done", {126'd0, req_done}, 128'd0);
        sd_finished = 1'b1;
        tick();
        sd_finished = 1'b0;
        chk_val("c0_done", {126'd0, req_done}, 128'(2'b01));
        chk_val("c0_stat", {126'd0, resp_status}, 128'd0);
        tick();
        chk_val("c0_done_off", {126'd0, req_done}, 128'd0);
        chk_val("c0_idle",     {127'd0, busy}, 128'd0);
        chk_val("c0_nsend",    128'(n_send - s0), 128'd1);
        chk_val("c0_nrecv",    128'(n_recv - r0), 128'd0);

        // R1 from requester 1, req_valid disturbed mid-flight
        req_cmd1 = C2; req_rtype1 = 2'd1; req_valid = 2'b10;
        tick();
        chk_val("r1_grant", {126'd0, req_grant}, 128'(2'b10));
        chk_val("r1_cmd",   {90'd0, send_cmd_content}, 128'(C2));
        chk_val("r1_r2r3",  {126'd0, R2_response, R3_response}, 128'd0);
        req_valid = 2'b00;
        tick();
        req_valid = 2'b01; req_cmd0 = 38'h3F_FFFF_FFFF;
        sd_finished = 1'b1;
        tick();
        sd_finished = 1'b0;
        chk_val("r1_ren",      {127'd0, receive_en}, 128'd1);
        chk_val("r1_cmd_hold", {90'd0, send_cmd_content}, 128'(C2));
        req_valid = 2'b00;
        tick();
        chk_val("r1_ren_off", {127'd0, receive_en}, 128'd0);
        sd_receive_started = 1'b1;
        tick();
        sd_receive_started = 1'b0;
        response = 127'h5A5A; sd_receive_finished = 1'b1;
        tick();
        sd_receive_finished = 1'b0; response = '0;
        chk_val("r1_done", {126'd0, req_done}, 128'(2'b10));
        chk_val("r1_stat", {126'd0, resp_status}, 128'd0);
        chk_val("r1_data", {1'b0, resp_data}, 128'h5A5A);
        tick();
        chk_val("r1_idle", {127'd0, busy}, 128'd0);

        // R2 with CRC error; counter freezes once started
        req_cmd0 = C3; req_rtype0 = 2'd2; req_valid = 2'b01;
        tick();
        chk_val("r2_sel",  {126'd0, R2_response, R3_response}, 128'(2'b10));
        req_valid = 2'b00;
        to_wait_resp();
        tick();
        tick();
        sd_receive_started = 1'b1;
        tick();
        sd_receive_started = 1'b0;
        repeat (20) tick();
        chk_val("r2_freeze_no_done", {126'd0, req_done}, 128'd0);
        chk_val("r2_freeze_busy",    {127'd0, busy}, 128'd1);
        chk_val("r2_sel_mid",        {127'd0, R2_response}, 128'd1);
        response = RV_R2; crc_response_err = 1'b1; sd_receive_finished = 1'b1;
        tick();
        sd_receive_finished = 1'b0; crc_response_err = 1'b0; response = '0;
        chk_val("r2_done",    {126'd0, req_done}, 128'(2'b01));
        chk_val("r2_stat",    {126'd0, resp_status}, 128'd1);
        chk_val("r2_data",    {1'b0, resp_data}, {1'b0, RV_R2});
        chk_val("r2_sel_end", {127'd0, R2_response}, 128'd1);
        tick();

        // R3 with no start: timeout exactly TO cycles after leaving RECV
        req_rtype1 = 2'd3; req_valid = 2'b10;
        tick();
        chk_val("to_r3sel", {126'd0, R2_response, R3_response}, 128'(2'b01));
        req_valid = 2'b00;
        to_wait_resp();
        repeat (TO - 1) tick();
        chk_val("to_early", {126'd0, req_done}, 128'd0);
        tick();
        chk_val("to_done", {126'd0, req_done}, 128'(2'b10));
        chk_val("to_stat", {126'd0, resp_status}, 128'd2);
        chk_val("to_data", {1'b0, resp_data}, {1'b0, RV_R2});
        tick();

        // finish on the timeout edge: finish wins
        req_rtype1 = 2'd1; req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        to_wait_resp();
        repeat (TO - 1) tick();
        response = RV_TIE; sd_receive_finished = 1'b1;
        tick();
        sd_receive_finished = 1'b0; response = '0;
        chk_val("tie_done", {126'd0, req_done}, 128'(2'b10));
        chk_val("tie_stat", {126'd0, resp_status}, 128'd0);
        chk_val("tie_data", {1'b0, resp_data}, {1'b0, RV_TIE});
        tick();

        // reset in WAIT_RESP
        req_cmd0 = C3; req_rtype0 = 2'd1; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        to_wait_resp();
        tick();
        tick();
        chk_val("rst_mid_pre_busy", {127'd0, busy}, 128'd1);
        d0 = n_done;
        ex_resetn = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick();
        tick();
        ex_resetn = 1'b1;
        chk_val("rst_mid_no_done", 128'(n_done - d0), 128'd0);
        req_cmd1 = C1; req_rtype1 = 2'd0; req_valid = 2'b10;
        tick();
        chk_val("post_rst_grant", {126'd0, req_grant}, 128'(2'b10));
        chk_val("post_rst_cmd",   {90'd0, send_cmd_content}, 128'(C1));
        req_valid = 2'b00;
        tick();
        sd_finished = 1'b1;
        tick();
        sd_finished = 1'b0;
        chk_val("post_rst_done", {126'd0, req_done}, 128'(2'b10));
        chk_val("post_rst_stat", {126'd0, resp_status}, 128'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/sd_cmd_arbiter.md
SD_CMD_ARBITER -- requirements
Module: sd_cmd_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: max ex_clk cycles from receive_en to sd_receive_started before timeout.
REQ-002 Parameter TO_W, default 13: timeout counter width; SHALL satisfy 2^TO_W > TIMEOUT_CYCLES.
REQ-003 ex_clk  in  1  sole clock; all logic rising-edge.
REQ-004 ex_resetn  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  2  per-requester command request; bit0 = init FSM, bit1 = host/UART.
REQ-006 req_cmd0, req_cmd1  in  38 each  command content (index+argument) per requester.
REQ-007 req_rtype0, req_rtype1  in  2 each  response type: 0 none, 1 R1/R6/R7 48-bit, 2 R2 136-bit, 3 R3.
REQ-008 req_grant  out  2  one-hot; requester's command accepted this cycle.
REQ-009 req_done  out  2  one-hot, one-cycle pulse; transaction of that requester complete.
REQ-010 resp_status  out  2  valid with req_done: 0 OK, 1 CRC error, 2 timeout.
REQ-011 resp_data  out  127  captured response; held until the next capture.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 send_en  out  1  one-cycle start pulse to the command sender.
REQ-014 send_cmd_content  out  38  command to the sender; held stable from grant to DONE.
REQ-015 sd_sending, sd_finished  in  1 each  sender status; sd_finished is a pulse.
REQ-016 receive_en  out  1  one-cycle start pulse to the response receiver.
REQ-017 R2_response, R3_response  out  1 each  response-type selects; held stable from grant to DONE.
REQ-018 sd_receive_started, sd_receive_finished, crc_response_err  in  1 each  receiver status.
REQ-019 response  in  127  receiver output; valid when sd_receive_finished is high.

Function
REQ-020 States SHALL be IDLE, SEND, WAIT_SEND, RECV, WAIT_RESP and DONE.
REQ-021 IDLE: when any req_valid bit is set, grant exactly one requester, latch its cmd/rtype, pulse req_grant, and go to SEND next cycle.
REQ-022 Fixed priority: requester 0 beats requester 1 when both are valid in the same cycle.
REQ-023 SEND: assert send_en for exactly one cycle, then go to WAIT_SEND.
REQ-024 WAIT_SEND on sd_finished: rtype 0 goes to DONE with status OK; otherwise go to RECV.
REQ-025 RECV: assert receive_en for one cycle, clear the timeout counter, then go to WAIT_RESP.
REQ-026 WAIT_RESP: the counter increments every cycle until sd_receive_started is seen, then freezes.
REQ-027 Counter reaching TIMEOUT_CYCLES before start goes to DONE with status 2; resp_data is unchanged.
REQ-028 sd_receive_finished goes to DONE; resp_data <= response; status is 1 if crc_response_err, else 0.
REQ-029 sd_receive_finished and timeout in the same cycle: finished wins.
REQ-030 DONE: pulse req_done for the owning requester for one cycle, then go to IDLE.
REQ-031 Re-arbitration is possible on the cycle after DONE; minimum 3 cycles between grants.
REQ-032 req_valid changes after grant SHALL NOT affect the transaction in flight.
REQ-033 A requester's req_valid held high through DONE is treated as a new request.

Reset
REQ-034 While ex_resetn is low, state = IDLE and every output = 0, including resp_data, send_cmd_content and the counter.
REQ-035 Reset mid-transaction aborts with no req_done pulse.

Configuration
REQ-036 Macro SD_ARB_ROUND_ROBIN_EN defined: the last-granted requester has lowest priority on simultaneous requests; the pointer resets to favour requester 0.
REQ-037 Macro undefined: fixed priority per REQ-022.

Verification
REQ-038 req_valid=01, cmd0=CMD0 (index 0, arg 0), rtype0=0 -> grant=01, one send_en, done=01 with status 0 one cycle after sd_finished, receive_en never asserted.
REQ-039 req_valid=10, rtype1=1, response=127'h5A5A returned with crc_response_err=0 -> resp_data=127'h5A5A, status 0, done=10.
REQ-040 req_valid=11 simultaneously, twice back-to-back -> fixed mode grants 01 then 01; with SD_ARB_ROUND_ROBIN_EN grants 01 then 10.
REQ-041 rtype=1, sd_receive_started never asserted, TIMEOUT_CYCLES=16 -> status 2 exactly 16 cycles after leaving RECV, resp_data unchanged.
REQ-042 rtype=2, crc_response_err=1 with sd_receive_finished -> status 1, R2_response=1 held throughout the transaction.
REQ-043 ex_resetn pulled low in WAIT_RESP -> all outputs 0 immediately, no req_done, next request served normally.
